// File: rtl/mux_pipe_xbar_pkg.sv
// Shared types and helpers for the mux_pipe_xbar selector.
// Optional out-of-range select checking is enabled by defining MUX_XBAR_CTRL_CHECK_EN.
package mux_pipe_xbar_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } skid_st_e;

   // Select width for n words; never narrower than one bit.
   function automatic int unsigned c_log_2(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_pipe_xbar_if.sv
// Upstream beat and downstream result signals of mux_pipe_xbar.
// ctrl_err only carries information when MUX_XBAR_CTRL_CHECK_EN is defined.
interface mux_pipe_xbar_if
   import mux_pipe_xbar_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_DATA   = 16,
   parameter int unsigned NUM_OUT    = 4,
   parameter int unsigned CTRL_WIDTH = c_log_2(NUM_DATA)
);
   logic                           in_valid;
   logic                           in_ready;
   logic [NUM_DATA*DATA_WIDTH-1:0] data_in;
   logic [NUM_OUT*CTRL_WIDTH-1:0]  ctrl_in;
   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_OUT*DATA_WIDTH-1:0]  data_out;
   logic                           ctrl_err;

   modport master (
      output in_valid, data_in, ctrl_in, out_ready,
      input  in_ready, out_valid, data_out, ctrl_err
   );

   modport slave (
      input  in_valid, data_in, ctrl_in, out_ready,
      output in_ready, out_valid, data_out, ctrl_err
   );
endinterface

// File: rtl/mux_lane_select.sv
// One output lane: picks a word by index, zero when the index is out of range.
// oor_o exists only when MUX_XBAR_CTRL_CHECK_EN is defined.
module mux_lane_select #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_DATA   = 16,
   parameter int unsigned CTRL_WIDTH = 4
) (
   input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
   input  logic [CTRL_WIDTH-1:0]          sel_i,
   output logic [DATA_WIDTH-1:0]          word_o
`ifdef MUX_XBAR_CTRL_CHECK_EN
   ,
   output logic                           oor_o
`endif
);

`ifdef MUX_XBAR_CTRL_CHECK_EN
   logic hit;
`endif

   // Indices with no matching word fall through to zero.
   always_comb begin
      word_o = '0;
`ifdef MUX_XBAR_CTRL_CHECK_EN
      hit = 1'b0;
`endif
      for (int unsigned i = 0; i < NUM_DATA; i++) begin
         if (sel_i == CTRL_WIDTH'(i)) begin
            word_o = data_i[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef MUX_XBAR_CTRL_CHECK_EN
            hit = 1'b1;
`endif
         end
      end
   end

`ifdef MUX_XBAR_CTRL_CHECK_EN
   assign oor_o = ~hit;
`endif

endmodule

// File: rtl/mux_pipe_xbar.sv
// Registered N-to-M word selector behind a valid/ready handshake with a 2-entry skid buffer.
// Defining MUX_XBAR_CTRL_CHECK_EN adds the sticky out-of-range select flag.
module mux_pipe_xbar
   import mux_pipe_xbar_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_DATA   = 16,
   parameter int unsigned NUM_OUT    = 4,
   parameter int unsigned CTRL_WIDTH = c_log_2(NUM_DATA)
) (
   input logic            clk,
   input logic            reset_n,
   mux_pipe_xbar_if.slave bus
);

   localparam int unsigned OutW = NUM_OUT * DATA_WIDTH;

   skid_st_e          st_q, st_d;
   logic [OutW-1:0]   main_q, main_d;
   logic [OutW-1:0]   skid_q, skid_d;
   logic [OutW-1:0]   sel_word;
   logic              in_ready_q, in_ready_d;
   logic              out_valid;
   logic              accept, emit;

`ifdef MUX_XBAR_CTRL_CHECK_EN
   logic [NUM_OUT-1:0] lane_oor;
   logic               ctrl_err_q;
`endif

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_lane
      mux_lane_select #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_DATA   (NUM_DATA),
         .CTRL_WIDTH (CTRL_WIDTH)
      ) u_lane (
         .data_i (bus.data_in),
         .sel_i  (bus.ctrl_in[j*CTRL_WIDTH +: CTRL_WIDTH]),
         .word_o (sel_word[j*DATA_WIDTH +: DATA_WIDTH])
`ifdef MUX_XBAR_CTRL_CHECK_EN
         ,
         .oor_o  (lane_oor[j])
`endif
      );
   end

   assign out_valid = (st_q != StEmpty);
   assign accept    = bus.in_valid & in_ready_q;
   assign emit      = out_valid & bus.out_ready;

   always_comb begin
      st_d   = st_q;
      main_d = main_q;
      skid_d = skid_q;
      unique case (st_q)
         StEmpty: begin
            if (accept) begin
               main_d = sel_word;
               st_d   = StOne;
            end
         end
         StOne: begin
            if (accept && emit) begin
               main_d = sel_word;
            end else if (accept) begin
               skid_d = sel_word;
               st_d   = StTwo;
            end else if (emit) begin
               st_d = StEmpty;
            end
         end
         StTwo: begin
            if (emit) begin
               main_d = skid_q;
               st_d   = StOne;
            end
         end
         default: st_d = StEmpty;
      endcase
      // Ready is a flop so it never combinationally follows out_ready.
      in_ready_d = (st_d != StTwo);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q       <= StEmpty;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         st_q       <= st_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

`ifdef MUX_XBAR_CTRL_CHECK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_err_q <= 1'b0;
      end else if (accept && |lane_oor) begin
         ctrl_err_q <= 1'b1;
      end
   end
   assign bus.ctrl_err = ctrl_err_q;
`else
   assign bus.ctrl_err = 1'b0;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.data_out  = main_q;

endmodule

// File: tb/tb_mux_pipe_xbar.sv
// Randomized bench for mux_pipe_xbar against a queue-based reference model.
// Also covers a NUM_DATA=12 instance for out-of-range selects (MUX_XBAR_CTRL_CHECK_EN aware).
module tb_mux_pipe_xbar;

   localparam int DW  = 16;
   localparam int ND  = 16;
   localparam int NO  = 4;
   localparam int CW  = 4;
   localparam int ND2 = 12;
   localparam int OW  = NO * DW;

`ifdef MUX_XBAR_CTRL_CHECK_EN
   localparam bit ChkEn = 1'b1;
`else
   localparam bit ChkEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mux_pipe_xbar_if #(.DATA_WIDTH(DW), .NUM_DATA(ND), .NUM_OUT(NO), .CTRL_WIDTH(CW)) bus ();
   mux_pipe_xbar_if #(.DATA_WIDTH(DW), .NUM_DATA(ND2), .NUM_OUT(NO), .CTRL_WIDTH(CW)) bus2 ();

   mux_pipe_xbar #(.DATA_WIDTH(DW), .NUM_DATA(ND), .NUM_OUT(NO), .CTRL_WIDTH(CW)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   mux_pipe_xbar #(.DATA_WIDTH(DW), .NUM_DATA(ND2), .NUM_OUT(NO), .CTRL_WIDTH(CW)) u_dut2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus2)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_in = 0;
   int n_out = 0;
   logic [OW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Lane j takes word ctrl_j, or zero when ctrl_j names no word.
   function automatic logic [OW-1:0] ref_select(input logic [ND*DW-1:0] d,
                                                 input logic [NO*CW-1:0] c, input int nd);
      logic [OW-1:0] r;
      r = '0;
      for (int j = 0; j < NO; j++) begin
         int s;
         s = int'(c[j*CW +: CW]);
         if (s < nd) r[j*DW +: DW] = d[s*DW +: DW];
      end
      return r;
   endfunction

   task automatic rand_beat();
      logic [ND*DW-1:0] d;
      for (int i = 0; i < ND*DW/32; i++) d[i*32 +: 32] = $urandom;
      bus.data_in = d;
      bus.ctrl_in = 16'($urandom);
   endtask

   // One clock: compare against the model at negedge, then advance the model at posedge.
   task automatic cycle();
      logic [OW-1:0] w;
      bit acc, em;
      @(negedge clk);
      check_eq("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      check_eq("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) check_eq("data_out", bus.data_out, exp_q[0]);
      acc = bus.in_valid && (exp_q.size() < 2);
      em  = (exp_q.size() > 0) && bus.out_ready;
      w   = ref_select(bus.data_in, bus.ctrl_in, ND);
      @(posedge clk);
      #1;
      if (em) begin
         void'(exp_q.pop_front());
         n_out++;
      end
      if (acc) begin
         exp_q.push_back(w);
         n_in++;
      end
   endtask

   initial begin
      int n0, i0;
      logic [ND2*DW-1:0] d2;
      logic [NO*CW-1:0]  c2;

      bus.in_valid   = 1'b1;
      bus.out_ready  = 1'b1;
      bus.data_in    = '0;
      bus.ctrl_in    = '0;
      bus2.in_valid  = 1'b0;
      bus2.out_ready = 1'b1;
      bus2.data_in   = '0;
      bus2.ctrl_in   = '0;

      // Reset held with in_valid asserted.
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_data_out", bus.data_out, 64'd0);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_ctrl_err", 64'(bus.ctrl_err), 64'd0);
      bus.in_valid = 1'b0;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed beat: word i = 0x100+i, lanes 3..0 select {3,3,0,15}.
      for (int i = 0; i < ND; i++) bus.data_in[i*DW +: DW] = 16'(16'h100 + i);
      bus.ctrl_in  = {4'd3, 4'd3, 4'd0, 4'd15};
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      check_eq("directed_valid", 64'(bus.out_valid), 64'd1);
      check_eq("directed_lanes", bus.data_out, 64'h0103_0103_0100_010F);
      cycle();
      cycle();

      // Streaming with out_ready held high.
      n0 = n_out;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      bus.in_valid = 1'b0;
      repeat (3) cycle();
      check_eq("stream_count", 64'(n_out - n0), 64'd100);

      // Backpressure: three cycles of offered beats with out_ready low.
      i0 = n_in;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      check_eq("bp_accepted", 64'(n_in - i0), 64'd2);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) cycle();
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         rand_beat();
         cycle();
      end

      // Alternating out_ready with random in_valid.
      for (int i = 0; i < 1000; i++) begin
         bus.out_ready = i[0];
         bus.in_valid  = 1'($urandom_range(0, 1));
         rand_beat();
         cycle();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) cycle();
      check_eq("no_loss_dup", 64'(n_out), 64'(n_in));
      check_eq("model_drained", 64'(exp_q.size()), 64'd0);

      // Fill both entries, then reset asynchronously mid-cycle.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      bus.in_valid = 1'b0;
      check_eq("pre_rst_full", 64'(bus.in_ready), 64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("async_data_out", bus.data_out, 64'd0);
      check_eq("async_in_ready", 64'(bus.in_ready), 64'd1);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      n0 = n_out;
      bus.in_valid = 1'b1;
      rand_beat();
      cycle();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) cycle();
      check_eq("post_rst_count", 64'(n_out - n0), 64'd1);
      check_eq("pow2_ctrl_err", 64'(bus.ctrl_err), 64'd0);

      // NUM_DATA=12 instance: lane 1 selects 13.
      for (int i = 0; i < ND2; i++) d2[i*DW +: DW] = 16'(16'h200 + i);
      c2 = {4'd0, 4'd11, 4'd13, 4'd2};
      bus2.data_in  = d2;
      bus2.ctrl_in  = c2;
      bus2.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      check_eq("oor_valid", 64'(bus2.out_valid), 64'd1);
      check_eq("oor_lanes", bus2.data_out, ref_select((ND*DW)'(d2), c2, ND2));
      check_eq("oor_lane1_zero", 64'(bus2.data_out[DW +: DW]), 64'd0);
      check_eq("oor_lane0", 64'(bus2.data_out[0 +: DW]), 64'h202);
      check_eq("oor_ctrl_err", 64'(bus2.ctrl_err), 64'(ChkEn));
      c2 = {4'd1, 4'd2, 4'd3, 4'd4};
      bus2.ctrl_in  = c2;
      bus2.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      check_eq("inrange_lanes", bus2.data_out, ref_select((ND*DW)'(d2), c2, ND2));
      check_eq("ctrl_err_sticky", 64'(bus2.ctrl_err), 64'(ChkEn));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
